// File: rtl/sar_result_tx.sv
// UART-style serial transmitter for SAR results: edge-captured into a small FIFO,
// sent as start, data MSB-first, even parity and stop bit.
module sar_result_tx #(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           result,
  input  logic                        conv_done,
  input  logic                        clr_ovr,
  output logic                        txd,
  output logic                        busy,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              done_q, push, pop, full, empty, do_write, ovr_set;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic              par, par_d, bit_end, txd_d;

  assign push     = conv_done & ~done_q;
  assign full     = (count == FULL_LVL);
  assign empty    = (count == '0);
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_write = push & (~full | pop);
  assign ovr_set  = push & full & ~pop;
  assign bit_end  = (cnt == CNT_LAST);
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      done_q <= conv_done;
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, do_write} - {{PTR_W{1'b0}}, pop};
      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    idx_d   = idx;
    sh_d    = sh;
    par_d   = par;
    pop     = 1'b0;
    txd_d   = 1'b1;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        cnt_d   = '0;
        idx_d   = IDX_TOP;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        cnt_d = '0;
        if (idx == '0) state_d = PARITY;
        else begin
          sh_d  = sh << 1;
          idx_d = idx - 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        cnt_d   = '0;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      sh_d  = mem[rd_ptr];
      par_d = ^mem[rd_ptr];
    end
    // Line level is decoded from the next state so txd is a clean register output.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[DATA_W-1];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      txd   <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      sh    <= sh_d;
      par   <= par_d;
      txd   <= txd_d;
      busy  <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_sar_result_tx.sv
// Scoreboard bench for sar_result_tx: stimulus queues expected frames, a line
// monitor decodes txd and compares each frame against the queue.
module tb_sar_result_tx;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned CPB    = 4;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] result = '0;
  logic              conv_done = 1'b0;
  logic              clr_ovr = 1'b0;
  logic              txd, busy, overrun;
  logic [2:0]        fifo_level;

  int n_vec = 0;
  int n_fail = 0;
  int frames_seen = 0;
  int run_len = 0;
  int last_run = 0;
  logic [14:0] exp_q[$];

  sar_result_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .result(result), .conv_done(conv_done), .clr_ovr(clr_ovr),
    .txd(txd), .busy(busy), .overrun(overrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Length of the most recent completed busy run; a reset discards the run.
  always @(negedge clk) begin
    if (reset) run_len = 0;
    else if (busy) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
  end

  logic [14:0] frame_bits;
  bit          aborted;
  logic [14:0] exp_frame;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        aborted = 1'b0;
        frame_bits = '1;
        for (int b = 0; b < 15 && !aborted; b++) begin
          for (int c = 0; c < ((b == 0) ? 2 : 4); c++) begin
            @(negedge clk);
            if (reset) aborted = 1'b1;
          end
          frame_bits[14-b] = txd;
        end
        if (!aborted) begin
          frames_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(frame_bits), 32'h7fff_ffff);
          end else begin
            exp_frame = exp_q.pop_front();
            check("frame", 32'(frame_bits), 32'(exp_frame));
          end
        end
      end
    end
  end

  task automatic push(input logic [11:0] v, input logic p, input bit expect_tx);
    @(negedge clk);
    result = v;
    conv_done = 1'b1;
    if (expect_tx) exp_q.push_back({1'b0, v, p, 1'b1});
    @(negedge clk);
    conv_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check("idle_wait", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  int  f0;
  int  max_lvl;
  bit  stable;
  initial begin : stim
    // Reset and quiet idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0 || overrun !== 1'b0) stable = 1'b0;
    end
    check("idle_hold", 32'(stable), 32'd1);

    // Single frame 0xA5C: parity 0
    f0 = frames_seen;
    @(negedge clk);
    result = 12'hA5C;
    conv_done = 1'b1;
    exp_q.push_back({1'b0, 12'hA5C, 1'b0, 1'b1});
    @(negedge clk);
    conv_done = 1'b0;
    check("level_pre_pop", 32'(fifo_level), 32'd1);
    check("txd_after_e0", 32'(txd), 32'd1);
    @(negedge clk);
    check("txd_start", 32'(txd), 32'd0);
    check("busy_start", 32'(busy), 32'd1);
    check("level_after_pop", 32'(fifo_level), 32'd0);
    wait_idle();
    check("single_busy_len", 32'(last_run), 32'd60);
    check("single_frames", 32'(frames_seen - f0), 32'd1);

    // Level held high: one push only
    f0 = frames_seen;
    max_lvl = 0;
    @(negedge clk);
    result = 12'hFFF;
    conv_done = 1'b1;
    exp_q.push_back({1'b0, 12'hFFF, 1'b0, 1'b1});
    repeat (200) begin
      @(negedge clk);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end
    conv_done = 1'b0;
    wait_idle();
    check("hold_max_level", 32'(max_lvl), 32'd1);
    check("hold_frames", 32'(frames_seen - f0), 32'd1);
    check("hold_busy_len", 32'(last_run), 32'd60);

    // Back-to-back frames
    f0 = frames_seen;
    push(12'h001, 1'b1, 1'b1);
    push(12'h002, 1'b1, 1'b1);
    push(12'h003, 1'b0, 1'b1);
    wait_idle();
    check("b2b_busy_len", 32'(last_run), 32'd180);
    check("b2b_frames", 32'(frames_seen - f0), 32'd3);

    // Overrun: one in flight, four buffered, sixth dropped
    f0 = frames_seen;
    push(12'h111, 1'b1, 1'b1);
    push(12'h222, 1'b1, 1'b1);
    push(12'h333, 1'b0, 1'b1);
    push(12'h444, 1'b1, 1'b1);
    push(12'h555, 1'b0, 1'b1);
    check("pre_ovr_flag", 32'(overrun), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);
    push(12'h666, 1'b0, 1'b0);
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_level", 32'(fifo_level), 32'd4);
    @(negedge clk);
    result = 12'h777;
    conv_done = 1'b1;
    clr_ovr = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    clr_ovr = 1'b0;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    check("ovr_level_hold", 32'(fifo_level), 32'd4);
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);
    wait_idle();
    check("ovr_busy_len", 32'(last_run), 32'd300);
    check("ovr_frames", 32'(frames_seen - f0), 32'd5);

    // Reset during data bit 5 aborts the frame and flushes the FIFO
    push(12'h50A, 1'b0, 1'b0);
    push(12'h123, 1'b1, 1'b0);
    repeat (28) @(negedge clk);
    check("txd_bit5", 32'(txd), 32'd0);
    check("level_before_rst", 32'(fifo_level), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    f0 = frames_seen;
    push(12'h7E1, 1'b1, 1'b1);
    wait_idle();
    check("post_rst_busy_len", 32'(last_run), 32'd60);
    check("post_rst_frames", 32'(frames_seen - f0), 32'd1);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
